// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: FSM states, grant encodings
// and the starvation-counter width helper.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    ARB_ST_NORMAL,
    ARB_ST_FORCE
  } arb_state_e;

  typedef enum logic [1:0] {
    ARB_G_NONE,
    ARB_G_WB,
    ARB_G_MDU,
    ARB_G_DBG
  } arb_grant_e;

  // Counter width able to hold 0..max.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Pending-write scoreboard for MDU destinations: one bit per register,
// set on issue, cleared on MDU write-back, two combinational lookups.
module reg_scoreboard #(
  parameter int REGFILE_SIZE = 32,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_adr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_adr,
  input  logic [ADDR_W-1:0] radr1,
  input  logic [ADDR_W-1:0] radr2,
  output logic              hit1,
  output logic              hit2,
  output logic              busy
);

  logic [REGFILE_SIZE-1:0] pend, pend_nxt;

  // Clear first so a same-address set in the same cycle wins; $0 never pends.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_adr] = 1'b0;
    if (set_en && set_adr != '0) pend_nxt[set_adr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign hit1 = pend[radr1];
  assign hit2 = pend[radr2];
  assign busy = |pend;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port among WB, MDU and DBG,
// with MDU starvation forcing and a pending-write hazard scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int REGFILE_SIZE = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_adr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_adr,
  input  logic [ADDR_W-1:0] radr1,
  input  logic [ADDR_W-1:0] radr2,
  output logic              hazard,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wadr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CW = cnt_w(STARVE_MAX);

  arb_state_e        state, state_nxt;
  arb_grant_e        grant;
  logic              rr_dbg;
  logic [CW-1:0]     cnt;
  logic              starving;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_data;
  logic              hit1, hit2;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_ST_NORMAL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = ARB_G_NONE;
    wb_stall  = 1'b0;
    case (state)
      ARB_ST_NORMAL: begin
        if (wb_valid)                          grant = ARB_G_WB;
        else if (mdu_valid && (!dbg_valid || !rr_dbg)) grant = ARB_G_MDU;
        else if (dbg_valid)                    grant = ARB_G_DBG;
      end
      ARB_ST_FORCE: begin
        // One-cycle excursion: either MDU lands or it withdrew.
        wb_stall  = 1'b1;
        if (mdu_valid) grant = ARB_G_MDU;
        state_nxt = ARB_ST_NORMAL;
      end
      default: state_nxt = ARB_ST_NORMAL;
    endcase
    mdu_ready = (grant == ARB_G_MDU);
    dbg_ready = (grant == ARB_G_DBG);
    starving  = mdu_valid && !mdu_ready;
    if (state == ARB_ST_NORMAL && starving && cnt == CW'(STARVE_MAX - 1))
      state_nxt = ARB_ST_FORCE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      rr_dbg <= 1'b0;
    end else begin
      if (!starving)                    cnt <= '0;
      else if (cnt != CW'(STARVE_MAX))  cnt <= cnt + 1'b1;
      if (grant == ARB_G_MDU || grant == ARB_G_DBG) rr_dbg <= !rr_dbg;
    end
  end

  always_comb begin
    g_adr  = wb_adr;
    g_data = wb_data;
    case (grant)
      ARB_G_MDU: begin g_adr = mdu_adr; g_data = mdu_data; end
      ARB_G_DBG: begin g_adr = dbg_adr; g_data = dbg_data; end
      default: ;
    endcase
  end

  // Address/data hold on idle cycles; $0 grants complete but never write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_wadr  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (grant != ARB_G_NONE) && (g_adr != '0);
      if (grant != ARB_G_NONE) begin
        rf_wadr  <= g_adr;
        rf_wdata <= g_data;
      end
    end
  end

  reg_scoreboard #(.REGFILE_SIZE(REGFILE_SIZE), .ADDR_W(ADDR_W)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue_valid),
    .set_adr (issue_adr),
    .clr_en  (mdu_ready),
    .clr_adr (mdu_adr),
    .radr1   (radr1),
    .radr2   (radr2),
    .hit1    (hit1),
    .hit2    (hit2),
    .busy    (busy)
  );

  assign hazard = hit1 | hit2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, mdu_valid, dbg_valid, issue_valid;
  logic [4:0]  wb_adr, mdu_adr, dbg_adr, issue_adr, radr1, radr2;
  logic [31:0] wb_data, mdu_data, dbg_data;
  logic        wb_stall, mdu_ready, dbg_ready, hazard, busy, rf_we;
  logic [4:0]  rf_wadr;
  logic [31:0] rf_wdata;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.REGFILE_SIZE(32), .ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_adr(mdu_adr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .dbg_valid(dbg_valid), .dbg_adr(dbg_adr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .issue_valid(issue_valid), .issue_adr(issue_adr), .radr1(radr1), .radr2(radr2),
    .hazard(hazard), .busy(busy),
    .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    wb_valid = 0; mdu_valid = 0; dbg_valid = 0; issue_valid = 0;
    wb_adr = 0; mdu_adr = 0; dbg_adr = 0; issue_adr = 0; radr1 = 0; radr2 = 0;
    wb_data = 0; mdu_data = 0; dbg_data = 0;

    // 1. reset with every requester asserting
    rst_n = 0;
    wb_valid = 1; wb_adr = 3; wb_data = 32'h55;
    mdu_valid = 1; mdu_adr = 7; mdu_data = 32'h77;
    dbg_valid = 1; dbg_adr = 9; dbg_data = 32'h99;
    tick(); tick();
    chk("rst_we", rf_we, 0);
    chk("rst_wadr", rf_wadr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_mdu_rdy", mdu_ready, 0);
    chk("rst_dbg_rdy", dbg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hazard", hazard, 0);
    rst_n = 1; mdu_valid = 0; dbg_valid = 0;
    tick();
    chk("wb_we", rf_we, 1);
    chk("wb_wadr", rf_wadr, 3);
    chk("wb_wdata", rf_wdata, 32'h55);

    // 2. MDU and DBG alternate when WB is idle, starting with MDU
    wb_valid = 0;
    mdu_valid = 1; mdu_adr = 10; mdu_data = 32'hA0;
    dbg_valid = 1; dbg_adr = 11; dbg_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_mdu_rdy%0d", i), mdu_ready, (i % 2) == 0);
      chk($sformatf("rr_dbg_rdy%0d", i), dbg_ready, (i % 2) == 1);
      tick();
      chk($sformatf("rr_wadr%0d", i), rf_wadr, ((i % 2) == 0) ? 10 : 11);
    end
    mdu_valid = 0; dbg_valid = 0;
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_wadr_hold", rf_wadr, 11);
    chk("idle_wdata_hold", rf_wdata, 32'hB0);

    // 3. WB starves MDU for 4 cycles, then one forced MDU cycle
    wb_valid = 1; wb_adr = 4; wb_data = 32'h44;
    mdu_valid = 1; mdu_adr = 12; mdu_data = 32'hC0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("starve_stall%0d", i), wb_stall, 0);
      chk($sformatf("starve_mdu_rdy%0d", i), mdu_ready, 0);
      tick();
      chk($sformatf("starve_wadr%0d", i), rf_wadr, 4);
    end
    #1;
    chk("force_stall", wb_stall, 1);
    chk("force_mdu_rdy", mdu_ready, 1);
    tick();
    chk("force_wadr", rf_wadr, 12);
    chk("force_wdata", rf_wdata, 32'hC0);
    chk("after_force_stall", wb_stall, 0);
    chk("after_force_mdu_rdy", mdu_ready, 0);
    tick();
    chk("after_force_wadr", rf_wadr, 4);
    wb_valid = 0; mdu_valid = 0;
    tick();

    // 4. scoreboard hazard and clear on MDU handshake
    issue_valid = 1; issue_adr = 8;
    tick();
    issue_valid = 0; radr1 = 8; radr2 = 0;
    #1;
    chk("haz_r1", hazard, 1);
    chk("haz_busy", busy, 1);
    radr1 = 0; radr2 = 8;
    #1;
    chk("haz_r2", hazard, 1);
    radr2 = 9;
    #1;
    chk("haz_other", hazard, 0);
    radr1 = 8;
    mdu_valid = 1; mdu_adr = 8; mdu_data = 32'h88;
    #1;
    chk("haz_mdu_rdy", mdu_ready, 1);
    chk("haz_no_bypass", hazard, 1);
    tick();
    mdu_valid = 0;
    #1;
    chk("haz_cleared", hazard, 0);
    chk("busy_cleared", busy, 0);
    chk("haz_mdu_we", rf_we, 1);
    chk("haz_mdu_wadr", rf_wadr, 8);

    // 5. address 0 writes and issues are swallowed
    dbg_valid = 1; dbg_adr = 0; dbg_data = 32'hFFFF;
    #1;
    chk("r0_dbg_rdy", dbg_ready, 1);
    tick();
    dbg_valid = 0;
    chk("r0_we", rf_we, 0);
    issue_valid = 1; issue_adr = 0;
    tick();
    issue_valid = 0;
    chk("r0_busy", busy, 0);

    // 6. same-cycle set/clear on one address: set wins
    issue_valid = 1; issue_adr = 5;
    mdu_valid = 1; mdu_adr = 5; mdu_data = 32'h50;
    #1;
    chk("sc_mdu_rdy", mdu_ready, 1);
    tick();
    issue_valid = 0; mdu_valid = 0; radr1 = 5; radr2 = 0;
    #1;
    chk("sc_hazard", hazard, 1);
    chk("sc_busy", busy, 1);

    // reset while in FORCE
    wb_valid = 1; wb_adr = 2; wb_data = 32'h22;
    mdu_valid = 1; mdu_adr = 6; mdu_data = 32'h66;
    repeat (4) tick();
    chk("mid_force_stall", wb_stall, 1);
    rst_n = 0;
    tick();
    chk("rstf_stall", wb_stall, 0);
    chk("rstf_mdu_rdy", mdu_ready, 0);
    chk("rstf_busy", busy, 0);
    chk("rstf_we", rf_we, 0);
    rst_n = 1;
    tick();
    chk("rstf_wb_we", rf_we, 1);
    chk("rstf_wb_wadr", rf_wadr, 2);
    chk("rstf_no_early_force", wb_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
